// File: rtl/uart_cmd_responder.sv
// Serial command link: two 8N1 RX bytes -> 16-bit cmd/cmd_rdy; send_resp -> one 8N1 TX byte.
// Latency: cmd_rdy at low-byte stop mid-bit (+2 clk sync); TX start bit one clk after send_resp.
// Backpressure: none; send_resp while busy is dropped. Optional CMD_TIMEOUT_EN drops a stale high byte.
module uart_cmd_responder #(
   parameter int BAUD_DIV     = 5208,
   parameter int TIMEOUT_CLKS = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic        clr_cmd_rdy,
   output logic        cmd_rdy,
   output logic [15:0] cmd,
   input  logic        send_resp,
   input  logic [7:0]  resp,
   output logic        resp_sent,
   output logic        rx_err
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {WAIT_HI, WAIT_LO} byte_state_t;

   logic        rx_meta, rx_sync, rx_prev;
   rx_state_t   rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_tick, rx_start, byte_rdy, frame_err, timeout;
   byte_state_t byte_state;

   logic        tx_busy;
   logic [8:0]  tx_frame;
   logic [CW-1:0] tx_cnt;
   logic [3:0]  tx_bit;

   // The start bit is re-checked half a bit in; every later sample lands mid-bit.
   assign rx_tick   = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
   assign rx_start  = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
   assign byte_rdy  = (rx_state == RX_STOP) && rx_tick && rx_sync;
   assign frame_err = (rx_state == RX_STOP) && rx_tick && !rx_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         if (rx_state == RX_IDLE)
            rx_cnt <= '0;
         else if (rx_tick)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         case (rx_state)
            RX_IDLE: if (rx_start) rx_state <= RX_START;
            RX_START: begin
               if (rx_tick) begin
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                  rx_bit   <= '0;
               end
            end
            RX_DATA: begin
               if (rx_tick) begin
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end
            end
            RX_STOP: if (rx_tick) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   logic [TW-1:0] to_cnt;
   logic          to_run;

   // Only the idle gap between bytes is timed; any RX activity restarts it.
   assign to_run  = (byte_state == WAIT_LO) && (rx_state == RX_IDLE) && !rx_start;
   assign timeout = to_run && (to_cnt == TW'(TIMEOUT_CLKS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (!to_run || timeout)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_state <= WAIT_HI;
         cmd        <= '0;
         cmd_rdy    <= 1'b0;
         rx_err     <= 1'b0;
      end else begin
         rx_err <= frame_err | timeout;
         if (byte_rdy) begin
            if (byte_state == WAIT_HI) begin
               cmd[15:8]  <= rx_shift;
               cmd_rdy    <= 1'b0;
               byte_state <= WAIT_LO;
            end else begin
               cmd[7:0]   <= rx_shift;
               cmd_rdy    <= 1'b1;
               byte_state <= WAIT_HI;
            end
         end else begin
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            if (timeout) byte_state <= WAIT_HI;
         end
      end
   end

   // tx_frame holds the bits still to go (data then stop); TX holds the current bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         TX        <= 1'b1;
         tx_busy   <= 1'b0;
         tx_frame  <= '1;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         resp_sent <= 1'b0;
      end else if (!tx_busy) begin
         TX <= 1'b1;
         if (send_resp) begin
            TX        <= 1'b0;
            tx_busy   <= 1'b1;
            tx_frame  <= {1'b1, resp};
            tx_cnt    <= '0;
            tx_bit    <= '0;
            resp_sent <= 1'b0;
         end
      end else if (tx_cnt == BIT_LAST) begin
         tx_cnt <= '0;
         if (tx_bit == 4'd9) begin
            tx_busy   <= 1'b0;
            resp_sent <= 1'b1;
            TX        <= 1'b1;
         end else begin
            TX       <= tx_frame[0];
            tx_frame <= {1'b1, tx_frame[8:1]};
            tx_bit   <= tx_bit + 1'b1;
         end
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

endmodule
